// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - stall bit positions and the stall patterns used by the controller
//   - controller state encoding
//   - load-use hazard detection helper
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int STALL_WIDTH    = 6;

  // Bit positions inside the stall vector (1 = hold that register)
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  localparam logic [STALL_WIDTH-1:0] STALL_NONE    = '0;
  localparam logic [STALL_WIDTH-1:0] STALL_IF      = STALL_WIDTH'((1 << STALL_PC) | (1 << STALL_IF_ID));
  localparam logic [STALL_WIDTH-1:0] STALL_LOADUSE = STALL_IF | STALL_WIDTH'(1 << STALL_ID_EX);
  localparam logic [STALL_WIDTH-1:0] STALL_MEM     = STALL_LOADUSE
                                                   | STALL_WIDTH'((1 << STALL_EX_MEM) | (1 << STALL_MEM_WB));

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    IF_WAIT  = 2'd2
  } ctrl_state_e;

  // A load in EX writing a non-zero register that ID is about to read.
  function automatic logic load_use_hazard(
    input logic                      mem_read_ex,
    input logic                      reg_write_ex,
    input logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
    input logic                      rs1_rd_en_id,
    input logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
    input logic                      rs2_rd_en_id,
    input logic [REG_ADDR_WIDTH-1:0] rs2_addr_id
  );
    return mem_read_ex && reg_write_ex && (rd_addr_ex != '0) &&
           ((rs1_rd_en_id && (rs1_addr_id == rd_addr_ex)) ||
            (rs2_rd_en_id && (rs2_addr_id == rd_addr_ex)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller.
//   master: pipeline side, drives hazard sources, receives stall/flush/redirect
//   slave : controller side
interface pipe_hazard_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic                                       rs1_rd_en_id;
  logic                                       rs2_rd_en_id;
  logic [pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH-1:0] rs1_addr_id;
  logic [pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH-1:0] rs2_addr_id;
  logic                                       mem_read_ex;
  logic                                       reg_write_ex;
  logic [pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH-1:0] rd_addr_ex;
  logic                                       branch_taken_ex;
  logic [PC_WIDTH-1:0]                        branch_target_ex;
  logic                                       if_busy;
  logic                                       mem_busy;

  logic [pipe_hazard_ctrl_pkg::STALL_WIDTH-1:0] stall;
  logic                                       flush_if_id;
  logic                                       flush_id_ex;
  logic                                       flush_mem_wb;
  logic                                       redirect_valid;
  logic [PC_WIDTH-1:0]                        redirect_pc;
  logic [CNT_WIDTH-1:0]                       stall_cnt;
  logic [CNT_WIDTH-1:0]                       flush_cnt;
  logic                                       mem_timeout_err;

  modport master (
    output rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
    output mem_read_ex, reg_write_ex, rd_addr_ex,
    output branch_taken_ex, branch_target_ex, if_busy, mem_busy,
    input  stall, flush_if_id, flush_id_ex, flush_mem_wb,
    input  redirect_valid, redirect_pc, stall_cnt, flush_cnt, mem_timeout_err
  );

  modport slave (
    input  rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
    input  mem_read_ex, reg_write_ex, rd_addr_ex,
    input  branch_taken_ex, branch_target_ex, if_busy, mem_busy,
    output stall, flush_if_id, flush_id_ex, flush_mem_wb,
    output redirect_valid, redirect_pc, stall_cnt, flush_cnt, mem_timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : add one this cycle unless already all-ones
//   count    : current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipe_hazard_ctrl_if
//              inputs  - operand reads in ID, load/rd in EX, branch resolve,
//                        fetch and data-memory busy
//              outputs - stall vector, flush strobes, PC redirect,
//                        saturating stall/flush counters, timeout flag
// Priority: mem_busy > redirect (live or pending) > load-use > if_busy.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e             state_reg, state_next;
  logic                    pend_valid_reg, pend_valid_next;
  logic [PC_WIDTH-1:0]     pend_pc_reg, pend_pc_next;
  logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                    err_reg, err_next;

  logic [STALL_WIDTH-1:0]  stall;
  logic                    flush_if_id, flush_id_ex, flush_mem_wb;
  logic                    redirect_valid;
  logic [PC_WIDTH-1:0]     redirect_pc;
  logic [PC_WIDTH-1:0]     target;
  logic                    load_use;
  logic [CNT_WIDTH-1:0]    stall_cnt, flush_cnt;

  assign load_use = load_use_hazard(bus.mem_read_ex, bus.reg_write_ex, bus.rd_addr_ex,
                                    bus.rs1_rd_en_id, bus.rs1_addr_id,
                                    bus.rs2_rd_en_id, bus.rs2_addr_id);

  // A live branch is younger than anything pending, so its target wins.
  assign target = bus.branch_taken_ex ? bus.branch_target_ex : pend_pc_reg;

  always_comb begin
    stall           = STALL_NONE;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_mem_wb    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    state_next      = RUN;
    pend_valid_next = pend_valid_reg;
    pend_pc_next    = pend_pc_reg;

    if (rst) begin
      pend_valid_next = 1'b0;
      pend_pc_next    = '0;
    end else if (bus.mem_busy) begin
      // Freeze everything up to MEM/WB and drain WB with a bubble; a branch
      // held in EX (and any pending redirect) survives until release.
      stall        = STALL_MEM;
      flush_mem_wb = 1'b1;
      state_next   = MEM_WAIT;
    end else if (bus.branch_taken_ex || pend_valid_reg) begin
      flush_if_id = 1'b1;
      flush_id_ex = bus.branch_taken_ex;
      if (!bus.if_busy) begin
        redirect_valid  = 1'b1;
        redirect_pc     = target;
        flush_id_ex     = 1'b1;
        pend_valid_next = 1'b0;
      end else begin
        // Fetch cannot take the new PC yet: park the target until it can.
        stall           = STALL_IF;
        pend_valid_next = 1'b1;
        pend_pc_next    = target;
        state_next      = IF_WAIT;
      end
    end else if (load_use) begin
      stall       = STALL_LOADUSE;
      flush_id_ex = 1'b1;
      state_next  = bus.if_busy ? IF_WAIT : RUN;
    end else if (bus.if_busy) begin
      stall       = STALL_IF;
      flush_if_id = 1'b1;
      state_next  = IF_WAIT;
    end
  end

  // Data-memory watchdog: counts consecutive busy cycles, clears on exit.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (bus.mem_busy) begin
      if (wait_cnt_reg != WAIT_MAX) wait_cnt_next = wait_cnt_reg + 1'b1;
    end else if (state_reg == MEM_WAIT) begin
      wait_cnt_next = '0;
    end
    err_next = err_reg || (bus.mem_busy && (wait_cnt_next == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= '0;
      wait_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_pc_reg    <= pend_pc_next;
      wait_cnt_reg   <= wait_cnt_next;
      err_reg        <= err_next;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall != STALL_NONE),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_valid),
    .count (flush_cnt)
  );

  // Registered outputs are also masked so every output reads 0 while rst is high.
  assign bus.stall           = stall;
  assign bus.flush_if_id     = flush_if_id;
  assign bus.flush_id_ex     = flush_id_ex;
  assign bus.flush_mem_wb    = flush_mem_wb;
  assign bus.redirect_valid  = redirect_valid;
  assign bus.redirect_pc     = redirect_pc;
  assign bus.stall_cnt       = rst ? '0 : stall_cnt;
  assign bus.flush_cnt       = rst ? '0 : flush_cnt;
  assign bus.mem_timeout_err = err_reg && !rst;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. It generates the 6-bit `stall` vector and per-register flush/bubble strobes consumed by the `pc_reg`, `if_id_reg`, `id_ex_reg`, `ex_mem_reg` and `mem_wb_reg` pipeline registers. It resolves load-use hazards, instruction-fetch and data-memory wait states, and branch/jump redirects, including a redirect that arrives while fetch is busy. It also keeps saturating stall and flush performance counters and a data-memory timeout watchdog.

Parameters:
- `PC_WIDTH`, 32: width of the redirect target.
- `CNT_WIDTH`, 32: width of the performance counters.
- `MEM_TIMEOUT`, 255: maximum consecutive `MEM_WAIT` cycles before the error flag sets.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `rs1_rd_en_id` input 1: ID stage reads rs1.
- `rs2_rd_en_id` input 1: ID stage reads rs2.
- `rs1_addr_id` input `REG_ADDR_WIDTH`: ID rs1 address.
- `rs2_addr_id` input `REG_ADDR_WIDTH`: ID rs2 address.
- `mem_read_ex` input 1: EX instruction is a load.
- `reg_write_ex` input 1: EX instruction writes rd.
- `rd_addr_ex` input `REG_ADDR_WIDTH`: EX destination register.
- `branch_taken_ex` input 1: EX resolved a taken branch or jump.
- `branch_target_ex` input `PC_WIDTH`: redirect target.
- `if_busy` input 1: fetch not ready (icache miss).
- `mem_busy` input 1: data memory not ready.
- `stall` output 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- `flush_if_id` output 1: load a bubble into IF/ID.
- `flush_id_ex` output 1: load a bubble into ID/EX.
- `flush_mem_wb` output 1: load a bubble into MEM/WB.
- `redirect_valid` output 1: PC loads `redirect_pc` this cycle.
- `redirect_pc` output `PC_WIDTH`: new PC.
- `stall_cnt` output `CNT_WIDTH`: cycles with any `stall` bit set; saturating.
- `flush_cnt` output `CNT_WIDTH`: number of redirects taken; saturating.
- `mem_timeout_err` output 1: sticky watchdog flag.

Behaviour:
- Reset
  - While `rst` is high, all outputs are 0.
  - State goes to `RUN`; the pending-redirect register, wait counter and perf counters clear.
- Outputs
  - `stall`, flush and redirect outputs are combinational from the current state and inputs.
  - Counters and the error flag are registered.
- Load-use hazard condition: `mem_read_ex` & `reg_write_ex` & `rd_addr_ex`≠0 & ((`rs1_rd_en_id` & rs1==rd) | (`rs2_rd_en_id` & rs2==rd)).
- Priority, highest first: `mem_busy` > redirect (live or pending) > load-use > `if_busy`.
- States: `RUN`, `MEM_WAIT`, `IF_WAIT`.
- `mem_busy`, in any state
  - `stall`=6'b011111, `flush_mem_wb`=1; WB drains, so there is no double write-back.
  - A branch in EX is frozen, so `branch_taken_ex` persists and is acted on after release.
  - State goes to `MEM_WAIT`; the wait counter increments each cycle.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout_err` sets and stays set until `rst`.
  - The counter clears on exit.
  - The first cycle with `mem_busy`=0 is evaluated like `RUN`.
- Redirect, with `mem_busy`=0 and `branch_taken_ex`=1
  - If `if_busy`=0: `redirect_valid`=1, `redirect_pc`=`branch_target_ex`, `flush_if_id`=1, `flush_id_ex`=1, `stall`=0, `flush_cnt`+1.
  - If `if_busy`=1: latch the target into the pending register, assert `flush_if_id` and `flush_id_ex`, set `stall`=6'b000011, and go to `IF_WAIT`.
- `IF_WAIT`
  - While `if_busy`: `stall`=6'b000011, `flush_if_id`=1.
  - Downstream stages keep flowing unless stalled by a higher-priority condition.
  - On `if_busy` falling with a redirect pending: `redirect_valid`=1 with the latched target, pending clears, `flush_cnt`+1, return to `RUN`.
  - A new `branch_taken_ex` in `IF_WAIT` overwrites the pending target; the younger branch is already flushed, so the latest target wins.
- Load-use, with no higher-priority condition: `stall`=6'b000111, `flush_id_ex`=1, for exactly one cycle. The next cycle re-evaluates with the load now in MEM.
- `if_busy` alone in `RUN`: `stall`=6'b000011, `flush_if_id`=1, go to `IF_WAIT` with no pending redirect.
- `stall_cnt` increments on every cycle with `stall`≠0. Both counters saturate at all-ones.
- `rst` during `MEM_WAIT`/`IF_WAIT` aborts immediately; any pending redirect is discarded.

Decomposition:
- Add to `defines.sv`:
  - stall bit index constants `STALL_PC`..`STALL_WB`;
  - `STALL_NONE`, `STALL_LOADUSE`, `STALL_IF`, `STALL_MEM` vector constants;
  - a `ctrl_state_e` enum.
- One sub-module, `sat_counter` (parameter width, `inc` input), instantiated twice for the perf counters.

Test Plan:
- **Load-use:** `lw x5` in EX (`mem_read_ex`=1, `rd_addr_ex`=5), ID reads rs1=5 → one cycle of `stall`=000111 and `flush_id_ex`=1, then `stall`=0; `stall_cnt`=1.
- **x0 destination:** same as load-use but `rd_addr_ex`=0 → no stall.
- **Branch:** `branch_taken_ex`=1, target 0x100, `if_busy`=0 → `redirect_valid`=1, `redirect_pc`=0x100, both flushes 1, `flush_cnt`=1.
- **Branch during fetch miss:** target 0x200 while `if_busy`=1 for 3 cycles → three cycles of `stall`=000011; redirect 0x200 on the cycle `if_busy` falls; exactly one `redirect_valid`.
- **Memory wait with branch:** `mem_busy`=1 for 4 cycles with `branch_taken_ex`=1 and load-use present → `stall`=011111 and `flush_mem_wb`=1 for 4 cycles, then redirect; no load-use bubble issued.
- **Timeout and reset:** `mem_busy` held for 255+ cycles with `MEM_TIMEOUT`=255 → `mem_timeout_err` rises and stays set after `mem_busy` drops; pulsing `rst` clears all outputs and counters.
